fir_mac_sequencer: RTL and testbench

//   Time-multiplexed FIR controller: owns a TAPS-deep sample delay line and a writable

---
 rtl/fir_mac_sequencer.sv | 137 +++++++++++++
 tb/tb_fir_mac_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
// Time-multiplexed FIR filter controller. A TAPS-deep sample delay line and a
// writable coefficient bank feed one shared signed multiply-accumulate unit,
// which spends TAPS cycles per sample before presenting the result.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. A producer holding valid keeps its data
// stable until the transfer. in_ready is asserted only in IDLE with no
// coefficient write pending. out_valid is asserted only in OUT, and y_out
// is held until out_ready is seen. No input reaches any output without
// passing through a register, except coef_wr_en gating in_ready in IDLE.
module fir_mac_sequencer #(
  parameter int TAPS = 4,
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int OW   = 18,
  localparam int AW  = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] x_in,
  input  logic                 coef_wr_en,
  input  logic [AW-1:0]        coef_wr_addr,
  input  logic signed [CW-1:0] coef_wr_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] y_out,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  // Delay line (x[0] is the newest sample) and coefficient bank.
  logic signed [DW-1:0] x [TAPS];
  logic signed [CW-1:0] c [TAPS];

  logic signed [OW-1:0]    acc;
  logic [AW-1:0]           tap;
  logic                    last_tap;
  logic                    accept;
  logic                    coef_we;
  logic                    addr_ok;
  logic signed [DW+CW-1:0] prod;
  logic signed [OW-1:0]    prod_ext;
  logic signed [OW-1:0]    acc_sum;

  assign last_tap  = (tap == AW'(TAPS - 1));
  assign addr_ok   = (32'(coef_wr_addr) < TAPS);
  assign state_dbg = state;

  // Shared MAC: full-precision signed product, sign-extended, wrapping add.
  assign prod     = x[tap] * c[tap];
  assign prod_ext = OW'(prod);
  assign acc_sum  = acc + prod_ext;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and handshake/control decode.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    coef_we   = 1'b0;
    case (state)
      S_IDLE: begin
        busy     = 1'b0;
        // A coefficient write takes the cycle; the sample waits.
        in_ready = !coef_wr_en;
        accept   = in_valid && !coef_wr_en;
        coef_we  = coef_wr_en && addr_ok;
        if (accept) state_nx = S_MAC;
      end
      S_MAC: begin
        if (last_tap) state_nx = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Datapath: delay line shift, coefficient writes, accumulation, result hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        x[i] <= '0;
        c[i] <= CW'(1);
      end
      acc   <= '0;
      tap   <= '0;
      y_out <= '0;
    end else begin
      if (accept) begin
        for (int i = TAPS - 1; i > 0; i--) begin
          x[i] <= x[i-1];
        end
        x[0] <= x_in;
        acc  <= '0;
        tap  <= '0;
      end
      if (coef_we) begin
        c[coef_wr_addr] <= coef_wr_data;
      end
      if (state == S_MAC) begin
        acc <= acc_sum;
        tap <= last_tap ? '0 : tap + 1'b1;
        if (last_tap) begin
          y_out <= acc_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: a driver, a small filter model that predicts
// each result when a sample is driven, and an output scoreboard.
module tb_fir_mac_sequencer;

  localparam int TAPS = 4;
  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int OW   = 18;

  // Clock / reset block
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] x_in;
  logic          coef_wr_en;
  logic [1:0]    coef_wr_addr;
  logic [CW-1:0] coef_wr_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] y_out;
  logic          busy;
  logic [1:0]    state_dbg;

  fir_mac_sequencer #(.TAPS(TAPS), .DW(DW), .CW(CW), .OW(OW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .x_in         (x_in),
    .coef_wr_en   (coef_wr_en),
    .coef_wr_addr (coef_wr_addr),
    .coef_wr_data (coef_wr_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .y_out        (y_out),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, obs, obs, exp, exp, cyc);
    end
  endtask

  // Scoreboard state and filter model
  logic [OW-1:0] exp_q[$];
  int            acc_q[$];
  int            mx [TAPS];
  int            mc [TAPS];
  bit            prev_ov = 1'b0;

  function automatic void model_reset();
    for (int i = 0; i < TAPS; i++) begin
      mx[i] = 0;
      mc[i] = 1;
    end
  endfunction

  // Monitor: records accepts, checks latency on out_valid rise, pops results.
  always @(negedge clk) begin
    logic [OW-1:0] e;
    int            a;
    if (reset) begin
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (out_valid && !prev_ov) begin
        a = (acc_q.size() > 0) ? acc_q.pop_front() : -1000;
        check("latency", 64'(cyc - a), 64'(TAPS + 1));
      end
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("y_out", 64'(y_out), 64'(e));
      end
      prev_ov = out_valid;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    in_valid     = 1'b0;
    coef_wr_en   = 1'b0;
    coef_wr_addr = '0;
    coef_wr_data = '0;
    out_ready    = 1'b1;
    x_in         = '0;
    tick();
    tick();
    exp_q.delete();
    acc_q.delete();
    model_reset();
    reset = 1'b0;
    #1;
  endtask

  task automatic send_sample(input int s);
    int n;
    int sum;
    x_in     = DW'(s);
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("accept_wait", 64'(in_ready), 64'(1));
    for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = s;
    sum = 0;
    for (int k = 0; k < TAPS; k++) sum += mx[k] * mc[k];
    exp_q.push_back(OW'(sum));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic write_coef(input int a, input int d, input bit upd);
    coef_wr_en   = 1'b1;
    coef_wr_addr = 2'(a);
    coef_wr_data = CW'(d);
    #1;
    check("wr_in_ready", 64'(in_ready), 64'(0));
    if (upd) mc[a] = d;
    tick();
    coef_wr_en = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int n;
    int t1 [5];
    t1 = '{10, 20, 30, 40, 0};

    // 1: reset state, default coefficients, latency
    do_reset();
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_y_out", 64'(y_out), 64'(0));
    check("rst_state", 64'(state_dbg), 64'(0));
    foreach (t1[i]) send_sample(t1[i]);
    wait_drain();

    // 2: coefficient writes in IDLE
    do_reset();
    for (int i = 0; i < TAPS; i++) write_coef(i, i + 1, 1'b1);
    send_sample(10);
    send_sample(20);
    send_sample(30);
    wait_drain();

    // 3: output back-pressure
    out_ready = 1'b0;
    send_sample(40);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check("t3_ov_wait", 64'(out_valid), 64'(1));
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_ov", 64'(out_valid), 64'(1));
      check("t3_hold_y", 64'(y_out), 64'(exp_q[0]));
      check("t3_hold_in_ready", 64'(in_ready), 64'(0));
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("t3_ov_drop", 64'(out_valid), 64'(0));
    check("t3_in_ready_rise", 64'(in_ready), 64'(1));
    wait_drain();

    // 4: extreme negative operands, no wrap at 18 bits
    do_reset();
    for (int i = 0; i < TAPS; i++) write_coef(i, -128, 1'b1);
    for (int i = 0; i < 4; i++) send_sample(-128);
    wait_drain();

    // 5: coefficient write during MAC is ignored
    do_reset();
    send_sample(3);
    write_coef(0, 7, 1'b0);
    send_sample(4);
    wait_drain();

    // 6: reset mid-MAC clears everything including the delay line
    do_reset();
    send_sample(9);
    tick();
    reset = 1'b1;
    tick();
    check("t6_out_valid", 64'(out_valid), 64'(0));
    check("t6_in_ready", 64'(in_ready), 64'(1));
    check("t6_busy", 64'(busy), 64'(0));
    exp_q.delete();
    acc_q.delete();
    model_reset();
    reset = 1'b0;
    #1;
    send_sample(5);
    wait_drain();

    // Random-ish tail with random back-pressure-free samples
    for (int i = 0; i < 6; i++) send_sample($urandom_range(0, 255) - 128);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
